// File: rtl/reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_arbiter
// Description : Round-robin arbiter sharing one DW-bit capture register among
//               NREQ requesters. Grant, capture with one-cycle ack/valid, then
//               a programmable hold window before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int HOLD = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      data_ff,
    output logic               valid,
    output logic               busy
);

    localparam int              c_pw        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_pw:0]   c_nreq      = (c_pw + 1)'(NREQ);
    localparam logic [c_pw-1:0] c_last      = c_pw'(NREQ - 1);
    localparam logic [3:0]      c_hold_last = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;
    localparam logic [NREQ-1:0] c_one       = {{(NREQ - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_pw-1:0] r_ptr;
    logic [c_pw-1:0] r_win;
    logic [3:0]      r_hold_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [DW-1:0]   r_data;
    logic            r_valid;

    logic [NREQ-1:0] w_req_eff;
    logic            w_found;
    logic [c_pw-1:0] w_win;
    logic [c_pw:0]   w_idx;
    logic [c_pw-1:0] w_ptr_next;
    logic [DW-1:0]   w_data [NREQ];

    // Split the packed data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_data[gi] = data_in[gi*DW +: DW];
        end
    endgenerate

    // A requester just acknowledged cannot win again on the very next edge.
    assign w_req_eff = req & ~r_ack;

    // Circular priority search starting at the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_pw + 1)'(k);
            if (w_idx >= c_nreq) begin
                w_idx = w_idx - c_nreq;
            end
            if (!w_found && w_req_eff[w_idx[c_pw-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_pw-1:0];
            end
        end
    end

    // Pointer moves to the index just after the served requester.
    assign w_ptr_next = (r_win == c_last) ? '0 : r_win + 1'b1;

    // Arbitration FSM with registered grant, acknowledge and capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= c_one << w_win;
                        r_win   <= w_win;
                        r_state <= S_GRANT;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                S_GRANT: begin
                    r_gnt <= '0;
                    if (req[r_win]) begin
                        r_data  <= w_data[r_win];
                        r_ack   <= c_one << r_win;
                        r_valid <= 1'b1;
                        r_ptr   <= w_ptr_next;
                        if (HOLD > 0) begin
                            r_state    <= S_HOLD;
                            r_hold_cnt <= c_hold_last;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        // Withdrawn request: abort without capture.
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign data_ff = r_data;
    assign valid   = r_valid;
    assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire
